// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 binary-code-modulation scan driver:
// FSM state encoding and the bit positions of R/G/B within a panel data triple.
package hub75_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_SHIFT = 2'd0;
  localparam state_t ST_LATCH = 2'd1;
  localparam state_t ST_SHOW  = 2'd2;

  localparam int RGB_R = 0;
  localparam int RGB_G = 1;
  localparam int RGB_B = 2;

endpackage

// File: rtl/hub75_bcm_timer.sv
// SHOW-phase timing for one bit plane: end-of-phase flag and output-enable window.
// The dimming window only exists when HUB75_BRIGHTNESS_EN is defined.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int BCM_BASE = 1,
  parameter int CW       = 10,
  parameter int PW       = 3
) (
  input  logic [PW-1:0] plane,
  input  logic [CW-1:0] cnt,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]    level,
`endif
  output logic          show_last,
  output logic          show_on
);

  logic [CW-1:0] show_len;

  assign show_len  = CW'(BCM_BASE) << plane;
  assign show_last = (cnt == show_len - 1'b1);

`ifdef HUB75_BRIGHTNESS_EN
  logic [CW+7:0] prod;
  logic [CW-1:0] cnt_inc;

  // cnt < floor(len*level/256)  <=>  (cnt+1)*256 <= len*level, avoids dropping product bits
  assign prod    = {8'd0, show_len} * {{CW{1'b0}}, level};
  assign cnt_inc = cnt + 1'b1;
  assign show_on = ({cnt_inc, 8'd0} <= prod);
`else
  assign show_on = 1'b1;
`endif

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 panel scan driver: per bit plane shift a row out, latch it, then display it
// for BCM_BASE<<plane cycles. Optional global dimming via HUB75_BRIGHTNESS_EN.
module hub75_bcm_scan
  import hub75_pkg::*;
#(
  parameter int COLS     = 64,
  parameter int ROWS     = 32,
  parameter int BPC      = 8,
  parameter int BCM_BASE = 1,
  localparam int AW = $clog2(COLS),
  localparam int YW = $clog2(ROWS),
  localparam int PW = (BPC > 1) ? $clog2(BPC) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]     brightness,
`endif
  input  logic [BPC-1:0] r0,
  input  logic [BPC-1:0] g0,
  input  logic [BPC-1:0] b0,
  input  logic [BPC-1:0] r1,
  input  logic [BPC-1:0] g1,
  input  logic [BPC-1:0] b1,
  output logic [AW-1:0]  addrx,
  output logic [YW-1:0]  addry,
  output logic [2:0]     rgb0,
  output logic [2:0]     rgb1,
  output logic           sclk,
  output logic           latch,
  output logic           blank,
  output logic [PW-1:0]  plane,
  output logic           frame_start
);

  localparam int CW = $clog2(2*COLS + 2 + (BCM_BASE << (BPC-1))) + 1;
  localparam logic [CW-1:0] SHIFT_LAST = CW'(2*COLS + 1);
  localparam logic [CW-1:0] SAMPLE_END = CW'(2*COLS);
  localparam logic [PW-1:0] PLANE_LAST = PW'(BPC - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          run;
  logic          show_last;
  logic          show_on;
  logic          sample;

  // run holds everything idle for the first clock after reset so cycle 0 is a real SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      state <= ST_SHIFT;
      cnt   <= '0;
      plane <= '0;
      addry <= '0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            state <= ST_LATCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LATCH: state <= ST_SHOW;
        ST_SHOW: begin
          if (show_last) begin
            state <= ST_SHIFT;
            cnt   <= '0;
            if (plane == PLANE_LAST) begin
              plane <= '0;
              addry <= addry + 1'b1;
            end else begin
              plane <= plane + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_SHIFT;
      endcase
    end
  end

  // Odd SHIFT cycles carry the source's answer to the address issued the cycle before
  assign sample = run && (state == ST_SHIFT) && cnt[0] && (cnt < SAMPLE_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb0 <= '0;
      rgb1 <= '0;
    end else if (sample) begin
      rgb0[RGB_R] <= r0[plane];
      rgb0[RGB_G] <= g0[plane];
      rgb0[RGB_B] <= b0[plane];
      rgb1[RGB_R] <= r1[plane];
      rgb1[RGB_G] <= g1[plane];
      rgb1[RGB_B] <= b1[plane];
    end
  end

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] bright_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bright_q <= '0;
    else if (frame_start) bright_q <= brightness;
  end
`endif

  hub75_bcm_timer #(
    .BCM_BASE (BCM_BASE),
    .CW       (CW),
    .PW       (PW)
  ) u_timer (
    .plane     (plane),
    .cnt       (cnt),
`ifdef HUB75_BRIGHTNESS_EN
    .level     (bright_q),
`endif
    .show_last (show_last),
    .show_on   (show_on)
  );

  assign addrx       = (run && state == ST_SHIFT) ? cnt[AW:1] : '0;
  assign sclk        = run && (state == ST_SHIFT) && cnt[0] && (cnt >= CW'(2));
  assign latch       = run && (state == ST_LATCH);
  assign blank       = !(run && (state == ST_SHOW) && show_on);
  assign frame_start = run && (state == ST_SHIFT) && (cnt == '0) &&
                       (plane == '0) && (addry == '0);

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Randomized bench for hub75_bcm_scan: default-size instance plus a tiny 4x2x1 instance,
// both compared every cycle against an arithmetic position model of the scan.
module tb_hub75_bcm_scan;

  localparam int FRAME  = 41696;
  localparam int SFRAME = 24;
  localparam int ROWLEN = 1303;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic [5:0] addrx;
  logic [4:0] addry;
  logic [2:0] rgb0, rgb1, plane;
  logic       sclk, latch, blank, frame_start;

  logic [0:0] sr0, sg0, sb0, sr1, sg1, sb1;
  logic [1:0] saddrx;
  logic [0:0] saddry, splane;
  logic [2:0] srgb0, srgb1;
  logic       ssclk, slatch, sblank, sframe_start;

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] br = 8'd128;
`endif

  hub75_bcm_scan u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(br),
`endif
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .addrx(addrx), .addry(addry), .rgb0(rgb0), .rgb1(rgb1),
    .sclk(sclk), .latch(latch), .blank(blank), .plane(plane), .frame_start(frame_start)
  );

  hub75_bcm_scan #(.COLS(4), .ROWS(2), .BPC(1), .BCM_BASE(1)) u_small (
    .clk(clk), .rst_n(rst_n),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(br),
`endif
    .r0(sr0), .g0(sg0), .b0(sb0), .r1(sr1), .g1(sg1), .b1(sb1),
    .addrx(saddrx), .addry(saddry), .rgb0(srgb0), .rgb1(srgb1),
    .sclk(ssclk), .latch(slatch), .blank(sblank), .plane(splane), .frame_start(sframe_start)
  );

  int checks = 0;
  int failures = 0;

  // image memory: [instance][half][colour R/G/B][row][col]
  logic [7:0] img  [2][2][3][32][64];
  logic [7:0] pend [2][2][3];

  bit tracking = 1'b0;
  int t = 0;
  int last_fs = -1, slast_fs = -1, prev_ay = 0, hi_cnt = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Scan position of cycle tc: row, plane and offset within that plane's SHIFT/LATCH/SHOW run
  task automatic locate(input int inst, input int tc, output int row, output int pl,
                        output int o, output int cols, output int base);
    int rows, nb, rowlen, rem;
    cols = (inst == 0) ? 64 : 4;
    rows = (inst == 0) ? 32 : 2;
    nb   = (inst == 0) ? 8 : 1;
    base = 1;
    rowlen = 0;
    for (int p = 0; p < nb; p++) rowlen += 2*cols + 3 + (base << p);
    row = (tc / rowlen) % rows;
    rem = tc % rowlen;
    pl = 0;
    while (rem >= 2*cols + 3 + (base << pl)) begin
      rem -= 2*cols + 3 + (base << pl);
      pl++;
    end
    o = rem;
  endtask

  task automatic check_cycle(input int inst, input int tc, input int ax, input int ay,
                             input int pl_o, input int c0, input int c1, input int sk,
                             input int lt, input int bk, input int fs);
    int row, pl, o, cols, base, k, on_len, e0, e1;
    string p;
    p = (inst == 0) ? "big_" : "small_";
    locate(inst, tc, row, pl, o, cols, base);
    check_eq({p, "addry"}, ay, row);
    check_eq({p, "plane"}, pl_o, pl);
    check_eq({p, "frame_start"}, fs, (row == 0 && pl == 0 && o == 0) ? 1 : 0);
    check_eq({p, "latch"}, lt, (o == 2*cols + 2) ? 1 : 0);
    check_eq({p, "sclk"}, sk, (o >= 2 && o < 2*cols + 2 && (o % 2) == 1) ? 1 : 0);
    on_len = base << pl;
`ifdef HUB75_BRIGHTNESS_EN
    on_len = (on_len * int'(br)) >> 8;
`endif
    check_eq({p, "blank"}, bk, (o > 2*cols + 2 && (o - (2*cols + 3)) < on_len) ? 0 : 1);
    if (o < 2*cols) check_eq({p, "addrx"}, ax, o / 2);
    if (o >= 2 && o < 2*cols + 2) begin
      k  = (o - 2) / 2;
      e0 = {img[inst][0][2][row][k][pl], img[inst][0][1][row][k][pl], img[inst][0][0][row][k][pl]};
      e1 = {img[inst][1][2][row][k][pl], img[inst][1][1][row][k][pl], img[inst][1][0][row][k][pl]};
      check_eq({p, "rgb0"}, c0, e0);
      check_eq({p, "rgb1"}, c1, e1);
    end
  endtask

  always @(negedge clk) begin
    if (tracking) begin
      int row, pl, o, cols, base;
      check_cycle(0, t, addrx, addry, plane, rgb0, rgb1, sclk, latch, blank, frame_start);
      check_cycle(1, t, saddrx, saddry, splane, srgb0, srgb1, ssclk, slatch, sblank, sframe_start);
      if (frame_start) begin
        if (last_fs >= 0) check_eq("frame_interval", t - last_fs, FRAME);
        last_fs = t;
      end
      if (sframe_start) begin
        if (slast_fs >= 0) check_eq("small_frame_interval", t - slast_fs, SFRAME);
        slast_fs = t;
      end
      if (int'(addry) != prev_ay) begin
        check_eq("addry_step", addry, (prev_ay + 1) % 32);
        prev_ay = addry;
      end
      if (rgb0[0]) hi_cnt++;
      case (t)
        130: check_eq("latch_at_130", latch, 1);
        131: check_eq("blank_at_131", blank, 0);
        132: check_eq("plane_at_132", plane, 1);
        default: ;
      endcase
      // source answers the address of the cycle before; non-sampled cycles carry junk
      for (int inst = 0; inst < 2; inst++) begin
        locate(inst, t, row, pl, o, cols, base);
        for (int h = 0; h < 2; h++)
          for (int c = 0; c < 3; c++)
            if ((o % 2) == 0 && o < 2*cols) pend[inst][h][c] = img[inst][h][c][row][o/2];
            else pend[inst][h][c] = 8'($urandom);
      end
      t++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    r0 = pend[0][0][0]; g0 = pend[0][0][1]; b0 = pend[0][0][2];
    r1 = pend[0][1][0]; g1 = pend[0][1][1]; b1 = pend[0][1][2];
    sr0 = pend[1][0][0][0:0]; sg0 = pend[1][0][1][0:0]; sb0 = pend[1][0][2][0:0];
    sr1 = pend[1][1][0][0:0]; sg1 = pend[1][1][1][0:0]; sb1 = pend[1][1][2][0:0];
  end

  task automatic release_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    t = 0; last_fs = -1; slast_fs = -1; prev_ay = 0; hi_cnt = 0;
    tracking = 1'b1;
  endtask

  initial begin
    int row, pl, o, cols, base;
    bit found;
    for (int i = 0; i < 2; i++)
      for (int h = 0; h < 2; h++)
        for (int c = 0; c < 3; c++) begin
          pend[i][h][c] = 8'd0;
          for (int y = 0; y < 32; y++)
            for (int x = 0; x < 64; x++) img[i][h][c][y][x] = 8'($urandom);
        end
    r0 = 0; g0 = 0; b0 = 0; r1 = 0; g1 = 0; b1 = 0;
    sr0 = 0; sg0 = 0; sb0 = 0; sr1 = 0; sg1 = 0; sb1 = 0;

    repeat (3) @(negedge clk);
    check_eq("rst_addrx", addrx, 0);
    check_eq("rst_addry", addry, 0);
    check_eq("rst_plane", plane, 0);
    check_eq("rst_rgb0", rgb0, 0);
    check_eq("rst_rgb1", rgb1, 0);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_latch", latch, 0);
    check_eq("rst_blank", blank, 1);
    check_eq("rst_frame_start", frame_start, 0);
    check_eq("rst_small_blank", sblank, 1);

    release_reset();
    repeat (FRAME + 200) @(negedge clk);
    #1;
    check_eq("frame_seen", last_fs, FRAME);

    // reset in the middle of a SHIFT, while sclk is high and addrx is nonzero
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      #1;
      locate(0, t - 1, row, pl, o, cols, base);
      if (o == 51) found = 1'b1;
    end
    check_eq("find_shift51", found, 1);
    tracking = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_blank", blank, 1);
    check_eq("mid_rst_sclk", sclk, 0);
    check_eq("mid_rst_addrx", addrx, 0);
    check_eq("mid_rst_rgb0", rgb0, 0);
    check_eq("mid_rst_latch", latch, 0);
    check_eq("mid_rst_small_blank", sblank, 1);

    // single lit red pixel of weight 0x80 in column 5 of every row, everything else dark
    for (int h = 0; h < 2; h++)
      for (int c = 0; c < 3; c++)
        for (int y = 0; y < 32; y++)
          for (int x = 0; x < 64; x++) img[0][h][c][y][x] = 8'd0;
    for (int y = 0; y < 32; y++) img[0][0][0][y][5] = 8'h80;

    repeat (2) @(negedge clk);
    release_reset();
    repeat (2 * ROWLEN) @(negedge clk);
    #1;
    check_eq("col5_plane7_hits", hi_cnt, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
